// File: rtl/panel_input_conditioner.sv
// Panel input conditioner: synchronises, debounces and decodes the raw
// panel buttons and switches into the clean control bus used by the
// mode/display controller. Also owns pitch stepping, the pause toggle and
// the one-cycle key-press event.
// Optional build macro: KEY_REPEAT_EN enables auto-repeat of key_event while
// exactly one key stays held.

// Debounces one input or one switch group. The counter measures how many
// consecutive cycles the synced sample has held its current value while that
// value differs from the accepted one; any change of the sample restarts the
// count, so a vector never resolves to a mixture of old and new bits.
module panel_debounce #(
  parameter int W   = 1,
  parameter int DEB = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int CW = (DEB < 1) ? 1 : $clog2(DEB + 1);

  logic [W-1:0]  sync1;
  logic [W-1:0]  sync2;
  logic [W-1:0]  last_sample;
  logic [W-1:0]  stable;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          accept;

  // Two-flop synchroniser for the raw pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Next count: zero when the sample matches, restart at one on any change
  always_comb begin
    cnt_next = cnt + 1'b1;
    if (sync2 == stable) begin
      cnt_next = '0;
    end else if (sync2 != last_sample) begin
      cnt_next = CW'(1);
    end
  end

  assign accept = (sync2 != stable) && (cnt_next == CW'(DEB));

  // Accept the sample once it has held for DEB cycles, then clear the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable      <= '0;
      cnt         <= '0;
      last_sample <= '0;
    end else begin
      last_sample <= sync2;
      if (accept) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt_next;
      end
    end
  end

  assign dout = stable;

endmodule

module panel_input_conditioner #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int REPEAT_MS   = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] key_raw,
  input  logic       pitch_up_raw,
  input  logic       pitch_dn_raw,
  input  logic       pause_raw,
  input  logic [2:0] sw_mode,
  input  logic [1:0] sw_song,
  input  logic [1:0] sw_user,
  output logic [6:0] key,
  output logic [1:0] pitch,
  output logic       pause,
  output logic [2:0] mode,
  output logic [1:0] song_num,
  output logic [1:0] user,
  output logic       key_event,
  output logic [2:0] key_code
);

  localparam int DEB_CYCLES = CLK_FREQ / 1000 * DEBOUNCE_MS;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [9:0] btn_raw;
  logic [9:0] btn_db;
  logic [6:0] key_db;
  logic       up_db;
  logic       dn_db;
  logic       pause_db;
  logic [2:0] mode_db;
  logic [1:0] song_db;
  logic [1:0] user_db;

  logic [6:0] key_prev;
  logic       up_prev;
  logic       dn_prev;
  logic       pause_prev;
  logic [2:0] mode_prev;
  logic [1:0] song_prev;
  logic [0:0] state;
  logic       pause_q;
  logic [1:0] pitch_q;
  logic [2:0] code_q;

  logic [6:0] key_new;
  logic       new_event;
  logic       up_edge;
  logic       dn_edge;
  logic       pause_edge;
  logic       sel_change;
  logic       rep_fire;

  assign btn_raw = {pause_raw, pitch_dn_raw, pitch_up_raw, key_raw};

  // Every single-bit button gets its own debouncer and counter
  for (genvar i = 0; i < 10; i++) begin : g_btn
    panel_debounce #(.W(1), .DEB(DEB_CYCLES)) u_btn (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (btn_raw[i]),
      .dout (btn_db[i])
    );
  end

  assign key_db   = btn_db[6:0];
  assign up_db    = btn_db[7];
  assign dn_db    = btn_db[8];
  assign pause_db = btn_db[9];

  panel_debounce #(.W(3), .DEB(DEB_CYCLES)) u_mode (
    .clk(clk), .rst_n(rst_n), .din(sw_mode), .dout(mode_db)
  );
  panel_debounce #(.W(2), .DEB(DEB_CYCLES)) u_song (
    .clk(clk), .rst_n(rst_n), .din(sw_song), .dout(song_db)
  );
  panel_debounce #(.W(2), .DEB(DEB_CYCLES)) u_user (
    .clk(clk), .rst_n(rst_n), .din(sw_user), .dout(user_db)
  );

  function automatic logic [2:0] lowest_index(input logic [6:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign key_new    = key_db & ~key_prev;
  assign new_event  = (state == ST_RUN) && (key_new != 7'd0);
  assign up_edge    = up_db & ~up_prev;
  assign dn_edge    = dn_db & ~dn_prev;
  assign pause_edge = pause_db & ~pause_prev;
  assign sel_change = (mode_db != mode_prev) || (song_db != song_prev);

`ifdef KEY_REPEAT_EN
  localparam int REP_CYCLES = CLK_FREQ / 1000 * REPEAT_MS;
  localparam int RW = (REP_CYCLES < 2) ? 1 : $clog2(REP_CYCLES + 1);

  logic [RW-1:0] rep_cnt;
  logic          single_key;
  logic          rep_run;

  assign single_key = (key_db != 7'd0) && ((key_db & (key_db - 7'd1)) == 7'd0);
  assign rep_run    = (state == ST_RUN) && single_key && (key_db == key_prev);
  assign rep_fire   = rep_run && (rep_cnt == RW'(REP_CYCLES - 1));

  // Repeat timer: runs only while one key is held steadily in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (!rep_run || rep_fire) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  logic unused_repeat;
  assign unused_repeat = (REPEAT_MS != 0);
  assign rep_fire      = 1'b0;
`endif

  assign key_event = new_event || rep_fire;
  assign key_code  = new_event ? lowest_index(key_new) :
                     rep_fire  ? lowest_index(key_db)  : code_q;

  // Previous-cycle copies of the debounced values for edge/change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev   <= '0;
      up_prev    <= 1'b0;
      dn_prev    <= 1'b0;
      pause_prev <= 1'b0;
      mode_prev  <= '0;
      song_prev  <= '0;
      code_q     <= '0;
    end else begin
      key_prev   <= key_db;
      up_prev    <= up_db;
      dn_prev    <= dn_db;
      pause_prev <= pause_db;
      mode_prev  <= mode_db;
      song_prev  <= song_db;
      code_q     <= key_code;
    end
  end

  // Lock the keyboard on a mode/song change until every key is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else if (sel_change) begin
      state <= ST_LOCK;
    end else if ((state == ST_LOCK) && (key_db == 7'd0)) begin
      state <= ST_RUN;
    end
  end

  // Pause toggles on a press and is forced off by a mode/song change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_q <= 1'b0;
    end else if (sel_change) begin
      pause_q <= 1'b0;
    end else if (pause_edge) begin
      pause_q <= ~pause_q;
    end
  end

  // Saturating pitch stepping: 01 low, 00 middle, 10 high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pitch_q <= 2'b00;
    end else if (up_edge && !dn_edge) begin
      pitch_q <= (pitch_q == 2'b01) ? 2'b00 : 2'b10;
    end else if (dn_edge && !up_edge) begin
      pitch_q <= (pitch_q == 2'b10) ? 2'b00 : 2'b01;
    end
  end

  assign key      = (state == ST_RUN) ? key_db : 7'd0;
  assign pitch    = pitch_q;
  assign pause    = pause_q;
  assign mode     = mode_db;
  assign song_num = song_db;
  assign user     = user_db;

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Directed self-checking bench for panel_input_conditioner with
// CLK_FREQ=1000, DEBOUNCE_MS=4 (4-cycle debounce), REPEAT_MS=8.
module tb_panel_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] key_raw;
  logic       pitch_up_raw;
  logic       pitch_dn_raw;
  logic       pause_raw;
  logic [2:0] sw_mode;
  logic [1:0] sw_song;
  logic [1:0] sw_user;
  logic [6:0] key;
  logic [1:0] pitch;
  logic       pause;
  logic [2:0] mode;
  logic [1:0] song_num;
  logic [1:0] user;
  logic       key_event;
  logic [2:0] key_code;

  int total = 0;
  int bad   = 0;

  panel_input_conditioner #(
    .CLK_FREQ   (1000),
    .DEBOUNCE_MS(4),
    .REPEAT_MS  (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_raw     (key_raw),
    .pitch_up_raw(pitch_up_raw),
    .pitch_dn_raw(pitch_dn_raw),
    .pause_raw   (pause_raw),
    .sw_mode     (sw_mode),
    .sw_song     (sw_song),
    .sw_user     (sw_user),
    .key         (key),
    .pitch       (pitch),
    .pause       (pause),
    .mode        (mode),
    .song_num    (song_num),
    .user        (user),
    .key_event   (key_event),
    .key_code    (key_code)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic up, input logic dn);
    pitch_up_raw = up;
    pitch_dn_raw = dn;
    tick(10);
    pitch_up_raw = 1'b0;
    pitch_dn_raw = 1'b0;
    tick(10);
  endtask

  initial begin
    rst_n = 1'b0;
    key_raw = '0; pitch_up_raw = 0; pitch_dn_raw = 0; pause_raw = 0;
    sw_mode = '0; sw_song = '0; sw_user = '0;
    tick(2);
    checkOutput("rst_key",   8'(key), 8'h00);
    checkOutput("rst_pitch", 8'(pitch), 8'h00);
    checkOutput("rst_pause", 8'(pause), 8'h00);
    checkOutput("rst_mode",  8'(mode), 8'h00);
    checkOutput("rst_song",  8'(song_num), 8'h00);
    checkOutput("rst_user",  8'(user), 8'h00);
    checkOutput("rst_event", 8'(key_event), 8'h00);
    checkOutput("rst_code",  8'(key_code), 8'h00);
    rst_n = 1'b1;

    sw_mode = 3'b001;
    tick(10);
    checkOutput("mode_init", 8'(mode), 8'h01);

    // Single key: accepted exactly on edge 6
    key_raw = 7'b0000001;
    tick(5);
    checkOutput("k0_early", 8'(key), 8'h00);
    checkOutput("k0_early_ev", 8'(key_event), 8'h00);
    tick(1);
    checkOutput("k0_key", 8'(key), 8'h01);
    checkOutput("k0_ev", 8'(key_event), 8'h01);
    checkOutput("k0_code", 8'(key_code), 8'h00);
    tick(1);
    checkOutput("k0_ev_once", 8'(key_event), 8'h00);
    key_raw = 7'b0;
    tick(6);
    checkOutput("k0_rel_key", 8'(key), 8'h00);
    checkOutput("k0_rel_ev", 8'(key_event), 8'h00);
    tick(2);

    // Pause: short glitch ignored, full presses toggle
    pause_raw = 1; tick(3); pause_raw = 0; tick(10);
    checkOutput("pause_glitch", 8'(pause), 8'h00);
    pause_raw = 1; tick(10);
    checkOutput("pause_on", 8'(pause), 8'h01);
    pause_raw = 0; tick(10);
    checkOutput("pause_hold", 8'(pause), 8'h01);
    pause_raw = 1; tick(10);
    checkOutput("pause_off", 8'(pause), 8'h00);
    pause_raw = 0; tick(10);

    // Pitch stepping and saturation
    applyStimulus(1'b1, 1'b0);
    checkOutput("pitch_up1", 8'(pitch), 8'h02);
    applyStimulus(1'b1, 1'b0);
    checkOutput("pitch_up2", 8'(pitch), 8'h02);
    applyStimulus(1'b0, 1'b1);
    checkOutput("pitch_dn1", 8'(pitch), 8'h00);
    applyStimulus(1'b0, 1'b1);
    checkOutput("pitch_dn2", 8'(pitch), 8'h01);
    applyStimulus(1'b0, 1'b1);
    checkOutput("pitch_dn3", 8'(pitch), 8'h01);
    applyStimulus(1'b1, 1'b1);
    checkOutput("pitch_both", 8'(pitch), 8'h01);

    // Song group: a staggered change never shows a mixed value
    sw_song = 2'b01; tick(2);
    sw_song = 2'b11; tick(5);
    checkOutput("song_nomix", 8'(song_num), 8'h00);
    tick(1);
    checkOutput("song_new", 8'(song_num), 8'h03);
    tick(4);

    // Mode change locks keys and clears pause
    pause_raw = 1; tick(10); pause_raw = 0; tick(10);
    checkOutput("pause_pre_lock", 8'(pause), 8'h01);
    key_raw = 7'b0001000; tick(8);
    checkOutput("k3_key", 8'(key), 8'h08);
    checkOutput("k3_code", 8'(key_code), 8'h03);
    sw_mode = 3'b011; tick(6);
    checkOutput("mode_new", 8'(mode), 8'h03);
    checkOutput("k3_prelock", 8'(key), 8'h08);
    tick(1);
    checkOutput("lock_key", 8'(key), 8'h00);
    checkOutput("lock_pause", 8'(pause), 8'h00);
    tick(10);
    checkOutput("lock_held", 8'(key), 8'h00);
    checkOutput("lock_ev", 8'(key_event), 8'h00);
    key_raw = 7'b0; tick(8);
    key_raw = 7'b0001000; tick(6);
    checkOutput("unlock_key", 8'(key), 8'h08);
    checkOutput("unlock_ev", 8'(key_event), 8'h01);
    checkOutput("unlock_code", 8'(key_code), 8'h03);
    key_raw = 7'b0; tick(8);

    // User change does not lock
    key_raw = 7'b0000100; tick(8);
    sw_user = 2'b10; tick(7);
    checkOutput("user_new", 8'(user), 8'h02);
    checkOutput("user_nolock", 8'(key), 8'h04);
    tick(2);
    checkOutput("user_nolock2", 8'(key), 8'h04);
    key_raw = 7'b0; tick(8);

    // Two keys on one edge: lowest index reported, held afterwards
    key_raw = 7'b0000110; tick(6);
    checkOutput("k12_ev", 8'(key_event), 8'h01);
    checkOutput("k12_code", 8'(key_code), 8'h01);
    checkOutput("k12_key", 8'(key), 8'h06);
    tick(1);
    checkOutput("k12_ev_once", 8'(key_event), 8'h00);
    key_raw = 7'b0; tick(8);
    checkOutput("k12_code_hold", 8'(key_code), 8'h01);

    // Reset mid-debounce
    key_raw = 7'b0100000; tick(3);
    rst_n = 1'b0;
    key_raw = 7'b0; sw_mode = '0; sw_song = '0; sw_user = '0;
    #1;
    checkOutput("mid_rst_key",   8'(key), 8'h00);
    checkOutput("mid_rst_pitch", 8'(pitch), 8'h00);
    checkOutput("mid_rst_mode",  8'(mode), 8'h00);
    checkOutput("mid_rst_song",  8'(song_num), 8'h00);
    checkOutput("mid_rst_user",  8'(user), 8'h00);
    checkOutput("mid_rst_code",  8'(key_code), 8'h00);
    checkOutput("mid_rst_ev",    8'(key_event), 8'h00);
    tick(2);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      checkOutput("post_rst_ev", 8'(key_event), 8'h00);
      checkOutput("post_rst_key", 8'(key), 8'h00);
    end

    // Held key 5: repeat events only with KEY_REPEAT_EN
    key_raw = 7'b0100000; tick(6);
    checkOutput("k5_ev", 8'(key_event), 8'h01);
    checkOutput("k5_code", 8'(key_code), 8'h05);
    for (int c = 1; c <= 30; c++) begin
      logic exp_ev;
      tick(1);
`ifdef KEY_REPEAT_EN
      exp_ev = ((c % 8) == 0);
`else
      exp_ev = 1'b0;
`endif
      checkOutput("k5_repeat_ev", 8'(key_event), 8'(exp_ev));
      checkOutput("k5_repeat_code", 8'(key_code), 8'h05);
    end
    key_raw = 7'b0; tick(8);
    checkOutput("k5_rel_ev", 8'(key_event), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
